// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state type, default array sizes and row-slice helper for the systolic array blocks.
package sa_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  localparam int ROWS_DEF = 4;
  localparam int WIDTH_A_DEF = 16;
  function automatic int row_lsb(input int r, input int w);
    return r * w;
  endfunction
endpackage

// File: rtl/skew_line.sv
// skew_line: DEPTH-stage data+valid shift register with enable and synchronous clear.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
      vld <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
      vld <= '0;
    end else if (en) begin
      data[0] <= d;
      vld[0]  <= v;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
        vld[i]  <= vld[i-1];
      end
    end
  end
  assign q  = data[DEPTH-1];
  assign qv = vld[DEPTH-1];
endmodule

// File: rtl/ws_act_skew_feeder.sv
// ws_act_skew_feeder: diagonal activation skew feeder for the WS PE array; ACT_FEEDER_ZERO_GATE_EN marks zero elements invalid.
module ws_act_skew_feeder
  import sa_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int WIDTH_A = WIDTH_A_DEF,
  parameter int CNT_W   = $clog2(ROWS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH_A-1:0] in_vec,
  input  logic                    in_last,
  input  logic                    stall,
  output logic [ROWS*WIDTH_A-1:0] act_out,
  output logic [ROWS-1:0]         act_valid,
  output logic                    pipeline_en,
  output logic                    cell_en,
  output logic                    busy,
  output logic                    done
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic accept, adv;
  assign in_ready = ~stall & (state == IDLE | state == STREAM);
  assign accept   = in_valid & in_ready;
  assign adv      = ~stall & (state != DONE);
  always_comb begin
    state_n = state == DONE  ? IDLE :
              state == FLUSH ? (cnt == CNT_W'(1) ? DONE : FLUSH) :
              accept         ? (in_last ? FLUSH : STREAM) : state;
    cnt_n   = accept & in_last ? CNT_W'(ROWS - 1) :
              state == FLUSH   ? cnt - CNT_W'(1) : cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (~stall) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  assign pipeline_en = ~stall & (|act_valid);
  assign cell_en     = state == STREAM | state == FLUSH;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WIDTH_A-1:0] elem;
    logic               ev;
    assign elem = accept ? in_vec[row_lsb(r, WIDTH_A) +: WIDTH_A] : '0;
`ifdef ACT_FEEDER_ZERO_GATE_EN
    assign ev = accept & (|elem);
`else
    assign ev = accept;
`endif
    skew_line #(.DEPTH(r + 1), .WIDTH(WIDTH_A)) u_line (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .en    (adv),
      .d     (elem),
      .v     (ev),
      .q     (act_out[row_lsb(r, WIDTH_A) +: WIDTH_A]),
      .qv    (act_valid[r])
    );
  end
endmodule

// File: doc/ws_act_skew_feeder.md
# ws_act_skew_feeder

Activation feeder that sits directly upstream of the weight-stationary PE array. It accepts one activation vector per cycle (one element per array row) over a valid/ready handshake. Each row's stream is delayed by a row-dependent skew so that activations enter the array diagonally. It also drives the per-row valid flags and the array's `pipeline_en` / `cell_en` controls, and flushes the skew after the last vector of a tile.

## Interface
Parameters:
- `ROWS`, 4: number of array rows (vector elements); ≥ 2
- `WIDTH_A`, 16: activation element width
- `CNT_W`, $clog2(ROWS)+1: flush counter width

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `clear` in 1: synchronous clear of all state; same effect as reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: feeder can accept a vector this cycle
- `in_vec` in ROWS*WIDTH_A: element r at bits [r*WIDTH_A +: WIDTH_A]
- `in_last` in 1: last vector of the tile; sampled with the handshake
- `stall` in 1: downstream freeze; when high, no state advances
- `act_out` out ROWS*WIDTH_A: skewed activation per row, same packing as `in_vec`
- `act_valid` out ROWS: per-row element valid
- `pipeline_en` out 1: array pipeline advance
- `cell_en` out 1: array cell enable, high from first accept until end of flush
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse after the flush completes

## Operation
- FSM states:
  - IDLE
    - `in_valid & in_ready` → STREAM; that vector is accepted.
  - STREAM
    - `in_ready = ~stall`.
    - Accept with `in_last` = 1 → FLUSH, and the flush counter loads ROWS-1.
  - FLUSH
    - `in_ready` = 0.
    - The counter decrements on each non-stalled cycle.
    - Counter reaches 0 on an advance → DONE.
  - DONE
    - `done` = 1 for one cycle, then → IDLE.
    - `in_ready` = 0.
- `in_ready = ~stall & (state==IDLE | state==STREAM)`.
- Skew lines:
  - Row r has a shift register of r+1 stages. Stage 0 loads element r and the valid bit.
  - Row r output equals the element accepted r+1 advance cycles earlier.
  - An advance is any cycle with `stall` = 0 and state ≠ DONE.
- On an advance with no accept (bubble), or any advance in FLUSH, stage 0 of every row loads zero with valid = 0.
- `pipeline_en` = `~stall & (|act_valid)`.
- `cell_en` = 1 in STREAM and FLUSH, 0 in IDLE and DONE.
- Element widths pass through unchanged; no arithmetic is performed on data.
- Boundary conditions:
  - `stall` held: all registers, FSM state and counter freeze; `in_ready` = 0.
  - `stall` asserted in the same cycle as `in_valid`: no accept.
  - `in_last` on the first accept out of IDLE: go directly to FLUSH. IDLE→STREAM→FLUSH collapses, so the FSM goes IDLE→FLUSH.
  - `clear` or `rst` mid-tile: all skew stages, valids, counter and FSM return to reset values. No `done` is issued.
  - `clear` has priority over the handshake in the same cycle.
- Reset values:
  - `act_out` = 0, `act_valid` = 0
  - `pipeline_en` = 0, `cell_en` = 0, `busy` = 0, `done` = 0
  - `in_ready` = `~stall`
  - state = IDLE

## Timing
- Latency from accept to row r output valid: r+1 non-stalled cycles.
- Row 0 appears on the cycle after the accept.
- Throughput: 1 vector/cycle with no bubbles while `stall` = 0.
- Tile of N vectors, no stalls: first `act_valid[0]` at cycle 1 (accept at cycle 0); last `act_valid[ROWS-1]` at cycle N-1+ROWS.
- `done` goes high at cycle N+ROWS-1 when ROWS-1 ≥ 1, i.e. one cycle after the last flush advance.
- All outputs are registered except `in_ready` and `pipeline_en`, which are combinational from `stall` and state/valids.

## Configuration
- Macro `ACT_FEEDER_ZERO_GATE_EN`.
- When defined: an accepted element equal to zero enters its skew line with valid = 0. Downstream zero gating then skips the MAC. Data still shifts, and FSM and latency are unchanged.
- When undefined: every accepted element carries valid = 1 regardless of value.

## Structure
- Shared package `sa_pkg`:
  - FSM state typedef (IDLE, STREAM, FLUSH, DONE)
  - default `WIDTH_A` / `ROWS` constants
  - row-slice index helper
- One sub-module: `skew_line`, parameterised by `DEPTH` and `WIDTH`. It is a shift register with an enable, synchronous clear and valid bit, and is instantiated once per row with `DEPTH` = r+1.

## Test plan
- ROWS=4, WIDTH_A=16, 3 vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, `in_last` on the third, no stall → row 0 outputs 1,5,9 at cycles 1–3; row 3 outputs 4,8,12 at cycles 4–6; `done` at cycle 6; `busy` low at cycle 7.
- `stall` held high for 3 cycles after the second accept → all `act_out`/`act_valid` frozen and `in_ready` = 0 for those 3 cycles; the sequence then resumes with `done` shifted by 3.
- Single vector {7,7,7,7} with `in_last` out of IDLE → FSM goes IDLE→FLUSH; row r is valid at cycle r+1 only; `done` at cycle 4.
- `in_valid` gap (bubble) between two vectors → a zero/invalid slot propagates diagonally; `pipeline_en` stays high while any row is valid.
- `clear` asserted at cycle 2 of a 3-vector tile → next cycle all outputs are 0, state is IDLE, no `done` pulse; a fresh tile then completes normally.
- With `ACT_FEEDER_ZERO_GATE_EN`, vector {0,3,0,5} → `act_valid[0]` and `act_valid[2]` stay low for that slot while rows 1 and 3 carry 3 and 5. Without the macro, all four rows are valid.
